// File: rtl/rx_dma_sched.sv
// rx_dma_sched: round-robin frame scheduler from two RX queues into the bus-master FIFO, with per-port host rings.
// Define RX_DMA_DROP_COUNT_EN to build saturating per-port dropped-frame counters; otherwise they read zero.
module rx_dma_sched #(
  parameter int LEN_W = 12
) (
  input  logic        clk_125,
  input  logic        sys_rst,
  input  logic [1:0]  dma_enable,
  input  logic [19:0] dma_length,
  input  logic [29:0] dma1_addr_start,
  input  logic [29:0] dma2_addr_start,
  output logic [29:0] dma1_addr_cur,
  output logic [29:0] dma2_addr_cur,
  input  logic [17:0] phy1_dout,
  input  logic [17:0] phy2_dout,
  input  logic        phy1_empty,
  input  logic        phy2_empty,
  output logic        phy1_rd_en,
  output logic        phy2_rd_en,
  output logic [17:0] mst_din,
  output logic        mst_wr_en,
  input  logic        mst_full,
  output logic [1:0]  grant,
  output logic [15:0] drop1_cnt,
  output logic [15:0] drop2_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_RDHDR, S_CALC, S_H0, S_H1, S_H2, S_DATA, S_DROP
  } state_t;

  localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

  state_t           state_q, state_d;
  logic             sel_q, sel_d;      // frame owner: 0 = port1, 1 = port2
  logic             last_q, last_d;    // port served most recently
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] need_q, need_d;
  logic [29:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rd_left_q, rd_left_d;
  logic [LEN_W-1:0] wr_left_q, wr_left_d;
  logic             pend_q, pend_d;
  logic             buf_vld_q, buf_vld_d;
  logic [16:0]      buf_q, buf_d;
  logic [29:0]      cur1_q, cur1_d;
  logic [29:0]      cur2_q, cur2_d;

  logic             rd1, rd2, pop, wr;
  logic [17:0]      din;
  logic             cur_upd;
  logic [29:0]      cur_new;

  logic [17:0]      q_dout;
  logic             q_empty;
  logic [29:0]      start_sel, cur_sel;
  logic             en_sel;
  logic [LEN_W-1:0] need_c;
  logic [30:0]      end_w, sum_w, nxt_w;
  logic             hold_vld, can_wr;
  logic [16:0]      hold_w;

  assign q_dout    = sel_q ? phy2_dout : phy1_dout;
  assign q_empty   = sel_q ? phy2_empty : phy1_empty;
  assign start_sel = sel_q ? dma2_addr_start : dma1_addr_start;
  assign cur_sel   = sel_q ? cur2_q : cur1_q;
  assign en_sel    = sel_q ? dma_enable[1] : dma_enable[0];
  assign need_c    = LEN_W'(({1'b0, len_q} + {{LEN_W{1'b0}}, 1'b1}) >> 1);
  assign end_w     = {1'b0, start_sel} + {11'b0, dma_length};
  assign sum_w     = {1'b0, cur_sel} + 31'(need_c);
  assign nxt_w     = {1'b0, addr_q} + 31'(need_q);

  // Hold slot: a word is either parked in buf_q or on the queue output the cycle after a pop.
  assign hold_vld  = buf_vld_q | pend_q;
  assign hold_w    = buf_vld_q ? buf_q : q_dout[16:0];
  assign can_wr    = hold_vld & ~mst_full;

  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    last_d    = last_q;
    len_d     = len_q;
    need_d    = need_q;
    addr_d    = addr_q;
    rd_left_d = rd_left_q;
    wr_left_d = wr_left_q;
    pend_d    = 1'b0;
    buf_vld_d = buf_vld_q;
    buf_d     = buf_q;
    cur1_d    = cur1_q;
    cur2_d    = cur2_q;
    rd1       = 1'b0;
    rd2       = 1'b0;
    pop       = 1'b0;
    wr        = 1'b0;
    din       = '0;
    cur_upd   = 1'b0;
    cur_new   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (!phy1_empty && (phy2_empty || last_q)) begin
          sel_d = 1'b0; last_d = 1'b0; rd1 = 1'b1; state_d = S_RDHDR;
        end else if (!phy2_empty) begin
          sel_d = 1'b1; last_d = 1'b1; rd2 = 1'b1; state_d = S_RDHDR;
        end
      end
      S_RDHDR: begin
        if (q_dout[17]) begin
          len_d   = q_dout[LEN_W-1:0];
          state_d = S_CALC;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        need_d    = need_c;
        rd_left_d = len_q;
        wr_left_d = len_q;
        buf_vld_d = 1'b0;
        if (!en_sel || len_q == '0 || 20'(need_c) > dma_length) begin
          state_d = S_DROP;
        end else begin
          state_d = S_H0;
          if (sum_w > end_w) begin
            addr_d  = start_sel;
            cur_upd = 1'b1;
            cur_new = start_sel;
          end else begin
            addr_d  = cur_sel;
          end
        end
      end
      S_H0: begin
        if (!mst_full) begin
          wr = 1'b1; din = {2'b10, addr_q[29:14]}; state_d = S_H1;
        end
      end
      S_H1: begin
        if (!mst_full) begin
          wr = 1'b1; din = {2'b00, addr_q[13:0], 2'b00}; state_d = S_H2;
        end
      end
      S_H2: begin
        if (!mst_full) begin
          wr = 1'b1; din = {{(18-LEN_W){1'b0}}, len_q}; state_d = S_DATA;
        end
      end
      S_DATA: begin
        pop = ~q_empty & (rd_left_q != '0) & (~hold_vld | can_wr);
        if (pop) begin
          rd_left_d = rd_left_q - ONE;
          pend_d    = 1'b1;
        end
        if (can_wr) begin
          wr        = 1'b1;
          din       = {1'b0, hold_w};
          wr_left_d = wr_left_q - ONE;
          buf_vld_d = 1'b0;
          if (wr_left_q == ONE) begin
            state_d = S_IDLE;
            cur_upd = 1'b1;
            cur_new = (nxt_w == end_w) ? start_sel : nxt_w[29:0];
          end
        end else if (pend_q) begin
          buf_vld_d = 1'b1;
          buf_d     = q_dout[16:0];
        end
      end
      S_DROP: begin
        pop = ~q_empty & (rd_left_q != '0);
        if (pop) rd_left_d = rd_left_q - ONE;
        if (rd_left_q == '0 || (pop && rd_left_q == ONE)) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (cur_upd) begin
      if (sel_q) cur2_d = cur_new;
      else       cur1_d = cur_new;
    end
    // A disabled ring is parked at its base so re-enabling starts clean.
    if (!dma_enable[0]) cur1_d = dma1_addr_start;
    if (!dma_enable[1]) cur2_d = dma2_addr_start;
  end

  always_ff @(posedge clk_125) begin
    if (sys_rst) begin
      state_q   <= S_IDLE;
      sel_q     <= 1'b0;
      last_q    <= 1'b1;
      rd_left_q <= '0;
      wr_left_q <= '0;
      pend_q    <= 1'b0;
      buf_vld_q <= 1'b0;
      cur1_q    <= dma1_addr_start;
      cur2_q    <= dma2_addr_start;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      last_q    <= last_d;
      rd_left_q <= rd_left_d;
      wr_left_q <= wr_left_d;
      pend_q    <= pend_d;
      buf_vld_q <= buf_vld_d;
      cur1_q    <= cur1_d;
      cur2_q    <= cur2_d;
    end
  end

  always_ff @(posedge clk_125) begin
    len_q  <= len_d;
    need_q <= need_d;
    addr_q <= addr_d;
    buf_q  <= buf_d;
  end

  assign phy1_rd_en    = rd1 | (pop & ~sel_q);
  assign phy2_rd_en    = rd2 | (pop & sel_q);
  assign mst_wr_en     = wr;
  assign mst_din       = din;
  assign grant         = (state_q == S_IDLE) ? 2'b00 : (sel_q ? 2'b10 : 2'b01);
  assign dma1_addr_cur = cur1_q;
  assign dma2_addr_cur = cur2_q;

`ifdef RX_DMA_DROP_COUNT_EN
  logic [15:0] drop1_q, drop2_q;
  logic        drop_ent;

  assign drop_ent = (state_q == S_CALC) && (state_d == S_DROP);

  always_ff @(posedge clk_125) begin
    if (sys_rst) begin
      drop1_q <= '0;
      drop2_q <= '0;
    end else if (drop_ent) begin
      if (!sel_q && drop1_q != 16'hFFFF) drop1_q <= drop1_q + 16'd1;
      if (sel_q && drop2_q != 16'hFFFF)  drop2_q <= drop2_q + 16'd1;
    end
  end

  assign drop1_cnt = drop1_q;
  assign drop2_cnt = drop2_q;
`else
  assign drop1_cnt = 16'h0;
  assign drop2_cnt = 16'h0;
`endif

endmodule
